simpleuart_wb_ctrl: RTL and testbench
=====================================

Name: simpleuart_wb_ctrl

Overview:
Wishbone master controller that sequences one simpleuart_wb slave.
- After reset, programs the clock-divider register.
- Round-robin arbitrates two byte-stream transmit requesters onto the single UART transmitter.
- Polls the status register and drains received bytes into a one-entry holding register with a valid/ready output.
- Sits between the console/debug byte sources and the UART, so software never busy-waits on UART status.

Parameters:
- CLK_DIV, 32'd0, value written to the CD register after reset (Fc/Fb - 2).
- RX_EN, 1, when 0 the RX poll/read path is disabled; rx_valid_o is tied 0.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbm_adr_o  out  1  register select to UART: 0 = status/data, 1 = clock divider.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data: [7:0] data, [8] recv_buf_valid, [9] tx_busy.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select.
- wbm_stb_o  out  1  strobe.
- wbm_ack_i  in  1  acknowledge.
- tx0_data_i  in  8  requester 0 byte.
- tx0_valid_i  in  1  requester 0 valid.
- tx0_ready_o  out  1  requester 0 byte accepted.
- tx1_data_i  in  8  requester 1 byte.
- tx1_valid_i  in  1  requester 1 valid.
- tx1_ready_o  out  1  requester 1 byte accepted.
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  holding register full.
- rx_ready_i  in  1  consumer takes the byte.
- init_done_o  out  1  divider programmed.

Behaviour:
Reset (wb_rst_i high at posedge):
- All outputs 0; state = INIT.
- Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- Holding register cleared.
- Reset mid-transaction drops stb the next cycle; no ack is awaited.

Bus rules:
- Exactly one transaction is outstanding at a time.
- stb, adr, we, sel and dat are registered and held stable until the cycle wbm_ack_i=1.
- stb is cleared at the edge where ack is sampled, so the minimum transaction is 2 cycles (stb cycle + ack cycle).
- There is no timeout; stb waits indefinitely for ack.

States:
- INIT: write adr=1, we=1, sel=4'hF, dat=CLK_DIV. On ack: init_done_o <= 1, go to POLL.
- POLL: read adr=0, we=0, sel=4'b0010. sel[0] must be 0 so the status read does not consume the RX byte. On ack, latch bits [9:8] and go to DECIDE.
- DECIDE (1 cycle), in priority order:
  - RX_EN && recv_buf_valid && !rx_valid_o → RXRD.
  - Else if !tx_busy and any txN_valid_i → TXWR, granting round-robin: the requester other than last_grant wins when both are valid. Latch the granted byte and index.
  - Else → POLL.
- TXWR: write adr=0, we=1, sel=4'b0001, dat={24'd0, byte}. On ack: pulse the granted txN_ready_o for exactly 1 cycle, update last_grant, go to POLL.
- RXRD: read adr=0, we=0, sel=4'b0001. On ack: rx_data_o <= dat_i[7:0], rx_valid_o <= 1, go to POLL.

Handshakes and boundary conditions:
- A requester must hold valid and data until its ready pulse. Dropping valid after grant is illegal; the latched byte is still sent.
- rx_valid_o clears on the cycle rx_valid_i... correction: on the cycle rx_valid_o && rx_ready_i.
- While rx_valid_o=1, received bytes stay in the UART and are not read.
- RX service takes precedence over TX in DECIDE.
- Always POLL between consecutive TX writes, so tx_busy is re-sampled before each write.

Test Plan:
- Reset, ack slave with 1-cycle latency, CLK_DIV=32'd432 → first transaction is a write adr=1, sel=F, dat=432; init_done_o rises the cycle after ack; next transaction is a status read with sel=4'b0010.
- tx0 sends 0x41 while status returns tx_busy=1 for 3 polls, then 0 → exactly one write adr=0, sel=1, dat=0x41 after the 4th poll; tx0_ready_o pulses once.
- tx0 and tx1 continuously valid (0xAA, 0x55), tx_busy=0 → write order 0xAA, 0x55, 0xAA, 0x55; alternating ready pulses.
- Status returns recv_buf_valid=1, data 0x7E, rx_ready_i=0 → one data read (sel=1); rx_data_o=0x7E, rx_valid_o=1; no further data reads until rx_ready_i=1 for one cycle, after which rx_valid_o=0.
- recv_buf_valid=1 and tx0_valid=1 in the same poll → RX read issued before the TX write.
- Assert wb_rst_i while stb is high in TXWR → stb low the next cycle, no ready pulse, restart from INIT.

Source files
------------

// File: rtl/simpleuart_wb_ctrl.sv
// simpleuart_wb_ctrl: Wishbone master that sequences one simpleuart_wb slave.
// It programs the clock divider once after reset, then loops polling the
// status register. From each poll it either drains a received byte into a
// one-entry holding register, or forwards one byte from two round-robin
// arbitrated transmit requesters, or simply polls again.
module simpleuart_wb_ctrl #(
  parameter logic [31:0] CLK_DIV = 32'd0,
  parameter bit          RX_EN   = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  // Wishbone master port towards the UART
  output logic        wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,

  // Transmit requester 0
  input  logic [7:0]  tx0_data_i,
  input  logic        tx0_valid_i,
  output logic        tx0_ready_o,

  // Transmit requester 1
  input  logic [7:0]  tx1_data_i,
  input  logic        tx1_valid_i,
  output logic        tx1_ready_o,

  // Received byte holding register
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,

  output logic        init_done_o
);

  // Register map and byte-select patterns of the UART slave
  localparam logic       AdrData   = 1'b0;
  localparam logic       AdrDiv    = 1'b1;
  localparam logic [3:0] SelAll    = 4'hF;
  // Status read touches only byte 1 so the slave does not pop its RX byte.
  localparam logic [3:0] SelStatus = 4'b0010;
  localparam logic [3:0] SelData   = 4'b0001;

  typedef enum logic [2:0] {
    StInit,
    StPoll,
    StDecide,
    StTxWr,
    StRxRd
  } state_e;

  state_e      state_q, state_d;

  // Registered bus signals, held stable while stb is high
  logic        stb_q, stb_d;
  logic        adr_q, adr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;

  // Status bits captured from the last poll
  logic        tx_busy_q, tx_busy_d;
  logic        rbuf_valid_q, rbuf_valid_d;

  // Arbitration state
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        grant_pick;

  // Handshake outputs
  logic        tx0_ready_q, tx0_ready_d;
  logic        tx1_ready_q, tx1_ready_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        init_done_q, init_done_d;

  // Only the data byte and the two status flags of the read word carry meaning.
  logic        unused_dat_hi;
  assign unused_dat_hi = ^wbm_dat_i[31:10];

  // Round-robin pick: on a tie the requester other than the last winner goes.
  assign grant_pick = (tx0_valid_i && tx1_valid_i) ? ~last_grant_q : tx1_valid_i;

  // Next-state logic: each bus state first issues its transaction, then waits for ack.
  always_comb begin
    state_d      = state_q;
    stb_d        = stb_q;
    adr_d        = adr_q;
    we_d         = we_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    tx_busy_d    = tx_busy_q;
    rbuf_valid_d = rbuf_valid_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    tx_byte_d    = tx_byte_q;
    tx0_ready_d  = 1'b0;
    tx1_ready_d  = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    init_done_d  = init_done_q;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StInit: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          adr_d = AdrDiv;
          we_d  = 1'b1;
          sel_d = SelAll;
          dat_d = CLK_DIV;
        end else if (wbm_ack_i) begin
          stb_d       = 1'b0;
          init_done_d = 1'b1;
          state_d     = StPoll;
        end
      end

      StPoll: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          adr_d = AdrData;
          we_d  = 1'b0;
          sel_d = SelStatus;
          dat_d = 32'd0;
        end else if (wbm_ack_i) begin
          stb_d        = 1'b0;
          tx_busy_d    = wbm_dat_i[9];
          rbuf_valid_d = wbm_dat_i[8];
          state_d      = StDecide;
        end
      end

      StDecide: begin
        // RX is served first so incoming bytes are not lost behind TX traffic.
        if (RX_EN && rbuf_valid_q && !rx_valid_q) begin
          state_d = StRxRd;
        end else if (!tx_busy_q && (tx0_valid_i || tx1_valid_i)) begin
          grant_d   = grant_pick;
          tx_byte_d = grant_pick ? tx1_data_i : tx0_data_i;
          state_d   = StTxWr;
        end else begin
          state_d = StPoll;
        end
      end

      StTxWr: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          adr_d = AdrData;
          we_d  = 1'b1;
          sel_d = SelData;
          dat_d = {24'd0, tx_byte_q};
        end else if (wbm_ack_i) begin
          stb_d        = 1'b0;
          tx0_ready_d  = ~grant_q;
          tx1_ready_d  = grant_q;
          last_grant_d = grant_q;
          // Back to POLL so tx_busy is re-sampled before the next write.
          state_d      = StPoll;
        end
      end

      StRxRd: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          adr_d = AdrData;
          we_d  = 1'b0;
          sel_d = SelData;
          dat_d = 32'd0;
        end else if (wbm_ack_i) begin
          stb_d      = 1'b0;
          rx_data_d  = wbm_dat_i[7:0];
          rx_valid_d = 1'b1;
          state_d    = StPoll;
        end
      end

      default: begin
        stb_d   = 1'b0;
        state_d = StInit;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any open transaction.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= StInit;
      stb_q        <= 1'b0;
      adr_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'd0;
      dat_q        <= 32'd0;
      tx_busy_q    <= 1'b0;
      rbuf_valid_q <= 1'b0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      tx_byte_q    <= 8'd0;
      tx0_ready_q  <= 1'b0;
      tx1_ready_q  <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      stb_q        <= stb_d;
      adr_q        <= adr_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      tx_busy_q    <= tx_busy_d;
      rbuf_valid_q <= rbuf_valid_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      tx_byte_q    <= tx_byte_d;
      tx0_ready_q  <= tx0_ready_d;
      tx1_ready_q  <= tx1_ready_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      init_done_q  <= init_done_d;
    end
  end

  assign wbm_stb_o   = stb_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_dat_o   = dat_q;
  assign tx0_ready_o = tx0_ready_q;
  assign tx1_ready_o = tx1_ready_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = RX_EN && rx_valid_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_simpleuart_wb_ctrl.sv
// Bench for simpleuart_wb_ctrl: a 1-cycle-latency Wishbone slave model answers
// polls from a programmable status word; non-poll transactions and ready pulses
// are captured by a monitor and checked against expectations queued by each test.
module tb_simpleuart_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i = 32'd0;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        ack = 1'b0;
  logic [7:0]  tx0_data = 8'd0;
  logic        tx0_valid = 1'b0;
  logic        tx0_ready;
  logic [7:0]  tx1_data = 8'd0;
  logic        tx1_valid = 1'b0;
  logic        tx1_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        init_done;

  typedef struct {
    logic        adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          polls;   // status polls since previous non-poll txn; -1 = don't care
  } txn_t;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  int          rdy_q[$];
  int          poll_cnt = 0;
  int          busy_left = 0;
  logic [31:0] status_base = 32'd0;
  logic [31:0] rd_word = 32'd0;
  int          n_cmp = 0;
  int          n_fail = 0;

  simpleuart_wb_ctrl #(
    .CLK_DIV(32'd432),
    .RX_EN  (1'b1)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat_o),
    .wbm_dat_i  (dat_i),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_stb_o  (stb),
    .wbm_ack_i  (ack),
    .tx0_data_i (tx0_data),
    .tx0_valid_i(tx0_valid),
    .tx0_ready_o(tx0_ready),
    .tx1_data_i (tx1_data),
    .tx1_valid_i(tx1_valid),
    .tx1_ready_o(tx1_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  // Slave model: ack one cycle after stb, read data chosen when stb is first seen.
  always @(posedge clk) begin
    if (rst) begin
      ack <= 1'b0;
    end else if (stb && !ack) begin
      ack <= 1'b1;
      if (!we && sel == 4'b0010) begin
        if (busy_left > 0) begin
          dat_i <= 32'h0000_0200;
          busy_left = busy_left - 1;
        end else begin
          dat_i <= status_base;
        end
      end else if (!we) begin
        dat_i <= rd_word;
      end else begin
        dat_i <= 32'd0;
      end
    end else begin
      ack <= 1'b0;
    end
  end

  // Monitor: completed transactions (polls only counted) and ready pulses.
  always @(negedge clk) begin
    txn_t t;
    if (stb && ack) begin
      if (!we && !adr && sel == 4'b0010) begin
        poll_cnt++;
      end else begin
        t.adr = adr; t.we = we; t.sel = sel; t.dat = dat_o; t.polls = poll_cnt;
        obs_q.push_back(t);
        poll_cnt = 0;
      end
    end
    if (tx0_ready) rdy_q.push_back(0);
    if (tx1_ready) rdy_q.push_back(1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  function automatic txn_t mk(logic a, logic w, logic [3:0] s, logic [31:0] d, int p);
    txn_t t;
    t.adr = a; t.we = w; t.sel = s; t.dat = d; t.polls = p;
    return t;
  endfunction

  task automatic clear_sb();
    obs_q.delete(); exp_q.delete(); rdy_q.delete(); poll_cnt = 0;
  endtask

  task automatic wait_poll_acks(input int n, input string name);
    int got = 0;
    for (int i = 0; i < 400 && got < n; i++) begin
      @(negedge clk);
      if (stb && ack && !we && !adr && sel == 4'b0010) got++;
    end
    n_cmp++;
    if (got < n) begin
      n_fail++;
      $display("FAIL %s: saw %0d status polls, required %0d", name, got, n);
    end
  endtask

  task automatic wait_rdy(input int n, input string name);
    for (int i = 0; i < 600 && rdy_q.size() < n; i++) @(negedge clk);
    n_cmp++;
    if (rdy_q.size() < n) begin
      n_fail++;
      $display("FAIL %s: saw %0d ready pulses, required %0d", name, rdy_q.size(), n);
    end
  endtask

  task automatic wait_obs(input int n, input string name);
    for (int i = 0; i < 600 && obs_q.size() < n; i++) @(negedge clk);
    n_cmp++;
    if (obs_q.size() < n) begin
      n_fail++;
      $display("FAIL %s: saw %0d transactions, required %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    txn_t o, e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({stb, we, adr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_bus: stb/we/adr=%b, required 000", {stb, we, adr});
    end
    n_cmp++;
    if (sel !== 4'd0 || dat_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_sel_dat: sel=%h dat=%h, required 0 0", sel, dat_o);
    end
    n_cmp++;
    if ({tx0_ready, tx1_ready, rx_valid, init_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: rdy0/rdy1/rxv/init=%b, required 0000",
               {tx0_ready, tx1_ready, rx_valid, init_done});
    end
    n_cmp++;
    if (rx_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_rx_data: got %h, required 00", rx_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_sb();
    exp_q.push_back(mk(1'b1, 1'b1, 4'hF, 32'd432, -1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb && ack) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen || init_done !== 1'b0) begin
      n_fail++; $display("FAIL init_ack: seen=%0d init_done=%b, required 1 0", seen, init_done);
    end
    @(negedge clk);
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_fail++; $display("FAIL init_done_rise: got %b, required 1", init_done);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (stb) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen || adr !== 1'b0 || we !== 1'b0 || sel !== 4'b0010) begin
      n_fail++;
      $display("FAIL first_poll: seen=%0d adr=%b we=%b sel=%b, required 1 0 0 0010",
               seen, adr, we, sel);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL init_txn: no transaction observed, required dat=%0d", e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.adr !== e.adr || o.we !== e.we || o.sel !== e.sel || o.dat !== e.dat) begin
          n_fail++;
          $display("FAIL init_txn: got adr=%b we=%b sel=%h dat=%0d, required %b %b %h %0d",
                   o.adr, o.we, o.sel, o.dat, e.adr, e.we, e.sel, e.dat);
        end
      end
    end
  endtask

  task automatic test_tx_busy();
    txn_t o, e;
    @(posedge clk); #1;
    status_base = 32'h0000_0200;
    wait_poll_acks(3, "busy_setup");
    @(posedge clk); #1;
    tx0_data = 8'h41; tx0_valid = 1'b1;
    status_base = 32'd0; busy_left = 3;
    clear_sb();
    exp_q.push_back(mk(1'b0, 1'b1, 4'b0001, 32'h41, 4));
    wait_rdy(1, "busy_ready");
    tx0_valid = 1'b0;
    repeat (12) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL busy_write: no transaction observed, required dat=%h", e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.adr !== e.adr || o.we !== e.we || o.sel !== e.sel || o.dat !== e.dat ||
            o.polls != e.polls) begin
          n_fail++;
          $display("FAIL busy_write: got sel=%h dat=%h polls=%0d, required %h %h %0d",
                   o.sel, o.dat, o.polls, e.sel, e.dat, e.polls);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0 || rdy_q.size() != 1 || rdy_q[0] != 0) begin
      n_fail++;
      $display("FAIL busy_once: extra txns=%0d ready pulses=%0d, required 0 and one on tx0",
               obs_q.size(), rdy_q.size());
    end
  endtask

  task automatic test_round_robin();
    txn_t o, e;
    int exp_rdy[4] = '{0, 1, 0, 1};
    @(posedge clk); #1;
    rst = 1'b1;
    tx0_data = 8'hAA; tx0_valid = 1'b1;
    tx1_data = 8'h55; tx1_valid = 1'b1;
    status_base = 32'd0; busy_left = 0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    clear_sb();
    exp_q.push_back(mk(1'b1, 1'b1, 4'hF, 32'd432, -1));
    exp_q.push_back(mk(1'b0, 1'b1, 4'b0001, 32'hAA, 1));
    exp_q.push_back(mk(1'b0, 1'b1, 4'b0001, 32'h55, 1));
    exp_q.push_back(mk(1'b0, 1'b1, 4'b0001, 32'hAA, 1));
    exp_q.push_back(mk(1'b0, 1'b1, 4'b0001, 32'h55, 1));
    wait_rdy(4, "rr_ready");
    tx0_valid = 1'b0; tx1_valid = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rr_txn%0d: no transaction observed, required dat=%h", i, e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.adr !== e.adr || o.we !== e.we || o.sel !== e.sel || o.dat !== e.dat ||
            (e.polls >= 0 && o.polls != e.polls)) begin
          n_fail++;
          $display("FAIL rr_txn%0d: got adr=%b sel=%h dat=%h polls=%0d, required %b %h %h %0d",
                   i, o.adr, o.sel, o.dat, o.polls, e.adr, e.sel, e.dat, e.polls);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0 || rdy_q.size() != 4) begin
      n_fail++;
      $display("FAIL rr_count: extra txns=%0d ready pulses=%0d, required 0 and 4",
               obs_q.size(), rdy_q.size());
    end
    for (int i = 0; i < 4 && i < rdy_q.size(); i++) begin
      n_cmp++;
      if (rdy_q[i] != exp_rdy[i]) begin
        n_fail++;
        $display("FAIL rr_ready%0d: got requester %0d, required %0d", i, rdy_q[i], exp_rdy[i]);
      end
    end
  endtask

  task automatic test_rx();
    txn_t o, e;
    @(posedge clk); #1;
    clear_sb();
    rx_ready = 1'b0;
    status_base = 32'h0000_017E; rd_word = 32'h0000_007E;
    exp_q.push_back(mk(1'b0, 1'b0, 4'b0001, 32'd0, -1));
    wait_obs(1, "rx_read");
    repeat (40) @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL rx_single_read: got %0d data reads, required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o.adr !== e.adr || o.we !== e.we || o.sel !== e.sel) begin
        n_fail++;
        $display("FAIL rx_read_cmd: got adr=%b we=%b sel=%h, required %b %b %h",
                 o.adr, o.we, o.sel, e.adr, e.we, e.sel);
      end
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin
      n_fail++; $display("FAIL rx_hold: valid=%b data=%h, required 1 7e", rx_valid, rx_data);
    end
    @(posedge clk); #1;
    status_base = 32'd0;
    wait_poll_acks(2, "rx_quiet");
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rx_consume: valid=%b, required 0", rx_valid);
    end
    clear_sb();
    status_base = 32'h0000_0133; rd_word = 32'h0000_0033;
    exp_q.push_back(mk(1'b0, 1'b0, 4'b0001, 32'd0, -1));
    wait_obs(1, "rx_read2");
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    o = obs_q.pop_front();
    if (o.we !== e.we || o.sel !== e.sel || rx_valid !== 1'b1 || rx_data !== 8'h33) begin
      n_fail++;
      $display("FAIL rx_second: we=%b sel=%h valid=%b data=%h, required 0 1 1 33",
               o.we, o.sel, rx_valid, rx_data);
    end
    @(posedge clk); #1;
    status_base = 32'd0;
    wait_poll_acks(2, "rx_quiet2");
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_rx_priority();
    txn_t o, e;
    @(posedge clk); #1;
    status_base = 32'h0000_0200;
    wait_poll_acks(3, "prio_setup");
    @(posedge clk); #1;
    tx0_data = 8'h5A; tx0_valid = 1'b1;
    status_base = 32'h0000_01C3; rd_word = 32'h0000_00C3;
    clear_sb();
    exp_q.push_back(mk(1'b0, 1'b0, 4'b0001, 32'd0, -1));
    exp_q.push_back(mk(1'b0, 1'b1, 4'b0001, 32'h5A, 1));
    wait_rdy(1, "prio_ready");
    tx0_valid = 1'b0;
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL prio_txn%0d: no transaction observed, required we=%b", i, e.we);
      end else begin
        o = obs_q.pop_front();
        if (o.adr !== e.adr || o.we !== e.we || o.sel !== e.sel ||
            (e.we && o.dat !== e.dat)) begin
          n_fail++;
          $display("FAIL prio_txn%0d: got we=%b sel=%h dat=%h, required %b %h %h",
                   i, o.we, o.sel, o.dat, e.we, e.sel, e.dat);
        end
      end
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
      n_fail++; $display("FAIL prio_rx: valid=%b data=%h, required 1 c3", rx_valid, rx_data);
    end
    @(posedge clk); #1;
    status_base = 32'd0;
    wait_poll_acks(2, "prio_quiet");
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_txn();
    txn_t o, e;
    bit seen = 1'b0;
    @(posedge clk); #1;
    status_base = 32'd0;
    tx1_data = 8'h99; tx1_valid = 1'b1;
    clear_sb();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stb && we && !adr && sel == 4'b0001 && !ack) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL midrst_find: TX write strobe seen=0, required 1");
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stb !== 1'b0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_stb: stb=%b init_done=%b, required 0 0", stb, init_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (rdy_q.size() != 0) begin
      n_fail++; $display("FAIL midrst_ready: got %0d ready pulses, required 0", rdy_q.size());
    end
    clear_sb();
    exp_q.push_back(mk(1'b1, 1'b1, 4'hF, 32'd432, -1));
    exp_q.push_back(mk(1'b0, 1'b1, 4'b0001, 32'h99, 1));
    wait_rdy(1, "midrst_resend");
    tx1_valid = 1'b0;
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL midrst_txn%0d: no transaction observed, required dat=%h", i, e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.adr !== e.adr || o.we !== e.we || o.sel !== e.sel || o.dat !== e.dat) begin
          n_fail++;
          $display("FAIL midrst_txn%0d: got adr=%b sel=%h dat=%h, required %b %h %h",
                   i, o.adr, o.sel, o.dat, e.adr, e.sel, e.dat);
        end
      end
    end
    n_cmp++;
    if (rdy_q.size() == 0 || rdy_q[0] != 1) begin
      n_fail++; $display("FAIL midrst_grant: ready pulses=%0d, required one on tx1", rdy_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_tx_busy();
    test_round_robin();
    test_rx();
    test_rx_priority();
    test_reset_mid_txn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
